// File: rtl/rfphoenix_vec_wb.sv
// Vector writeback stage: 2-entry FIFO, per-lane predication merge, then two
// half-width vector RF beats or one mask RF beat, with a scoreboard clear.
module rfphoenix_vec_wb #(
  parameter int unsigned NLANES = 16,
  parameter int unsigned LW     = 32,
  parameter int unsigned RW     = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NLANES*LW-1:0]     in_o,
  input  logic [NLANES*LW-1:0]     in_t,
  input  logic [NLANES-1:0]        in_mask,
  input  logic                     in_zero,
  input  logic                     in_cmp,
  input  logic [RW-1:0]            in_tgt,
  input  logic                     flush,
  output logic                     rf_wr,
  output logic [RW-1:0]            rf_wa,
  output logic                     rf_wbeat,
  output logic [NLANES/2*LW-1:0]   rf_wd,
  output logic                     mrf_wr,
  output logic [2:0]               mrf_wa,
  output logic [NLANES-1:0]        mrf_wd,
  output logic                     sb_clr,
  output logic [RW-1:0]            sb_tgt,
  output logic                     busy
);

  localparam int unsigned VW = NLANES * LW;
  localparam int unsigned HW = VW / 2;

  typedef enum logic [1:0] {S_IDLE, S_BEAT0, S_BEAT1, S_MASK} state_e;

  state_e state_q, state_d;
  logic [1:0] count_q, count_d;
  logic       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

  logic [VW-1:0]     o_mem_q [2];
  logic [VW-1:0]     t_mem_q [2];
  logic [NLANES-1:0] m_mem_q [2];
  logic              z_mem_q [2];
  logic              c_mem_q [2];
  logic [RW-1:0]     g_mem_q [2];

  logic              rf_wr_q, rf_wr_d, rf_wbeat_q, rf_wbeat_d;
  logic [RW-1:0]     rf_wa_q, rf_wa_d, sb_tgt_q, sb_tgt_d;
  logic [HW-1:0]     rf_wd_q, rf_wd_d;
  logic              mrf_wr_q, mrf_wr_d, sb_clr_q, sb_clr_d;
  logic [2:0]        mrf_wa_q, mrf_wa_d;
  logic [NLANES-1:0] mrf_wd_q, mrf_wd_d;

  logic              push, pop, finishing;
  logic              sel_valid, sel_zero, sel_cmp;
  logic [VW-1:0]     sel_o, sel_t, merged;
  logic [NLANES-1:0] sel_mask, mwd;
  logic [RW-1:0]     sel_tgt;

  assign in_ready  = (count_q < 2'd2);
  assign busy      = (count_q != 2'd0) || (state_q != S_IDLE);
  assign finishing = (state_q == S_BEAT1) || (state_q == S_MASK);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = finishing && !flush;

  // Entry feeding the next registered outputs: after a pop it is the following
  // entry, taken straight from the inputs when it is being pushed this cycle.
  always_comb begin
    sel_valid = (count_q != 2'd0);
    sel_o     = o_mem_q[rd_ptr_q];
    sel_t     = t_mem_q[rd_ptr_q];
    sel_mask  = m_mem_q[rd_ptr_q];
    sel_zero  = z_mem_q[rd_ptr_q];
    sel_cmp   = c_mem_q[rd_ptr_q];
    sel_tgt   = g_mem_q[rd_ptr_q];
    if (finishing) begin
      sel_valid = (count_q == 2'd2) || push;
      if (count_q == 2'd2) begin
        sel_o    = o_mem_q[~rd_ptr_q];
        sel_t    = t_mem_q[~rd_ptr_q];
        sel_mask = m_mem_q[~rd_ptr_q];
        sel_zero = z_mem_q[~rd_ptr_q];
        sel_cmp  = c_mem_q[~rd_ptr_q];
        sel_tgt  = g_mem_q[~rd_ptr_q];
      end else begin
        sel_o    = in_o;
        sel_t    = in_t;
        sel_mask = in_mask;
        sel_zero = in_zero;
        sel_cmp  = in_cmp;
        sel_tgt  = in_tgt;
      end
    end
  end

  always_comb begin
    merged = '0;
    mwd    = '0;
    for (int unsigned n = 0; n < NLANES; n++) begin
      if (sel_mask[n])   merged[n*LW +: LW] = sel_o[n*LW +: LW];
      else if (!sel_zero) merged[n*LW +: LW] = sel_t[n*LW +: LW];
      mwd[n] = sel_o[n] & sel_mask[n];
    end
  end

  always_comb begin
    count_d  = flush ? 2'd0 : 2'(count_q + 2'(push) - 2'(pop));
    rd_ptr_d = flush ? 1'b0 : (rd_ptr_q ^ pop);
    wr_ptr_d = flush ? 1'b0 : (wr_ptr_q ^ push);
  end

  // Next state and the registered strobes/data for that state.
  always_comb begin
    state_d    = state_q;
    rf_wr_d    = 1'b0;
    rf_wa_d    = '0;
    rf_wbeat_d = 1'b0;
    rf_wd_d    = '0;
    mrf_wr_d   = 1'b0;
    mrf_wa_d   = '0;
    mrf_wd_d   = '0;
    sb_clr_d   = 1'b0;
    sb_tgt_d   = '0;
    if (flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_BEAT0) begin
      state_d = S_BEAT1;
    end else if (!sel_valid) begin
      state_d = S_IDLE;
    end else begin
      state_d = sel_cmp ? S_MASK : S_BEAT0;
    end
    case (state_d)
      S_BEAT0: begin
        rf_wr_d = 1'b1;
        rf_wa_d = sel_tgt;
        rf_wd_d = merged[HW-1:0];
      end
      S_BEAT1: begin
        rf_wr_d    = 1'b1;
        rf_wa_d    = sel_tgt;
        rf_wbeat_d = 1'b1;
        rf_wd_d    = merged[VW-1:HW];
        sb_clr_d   = 1'b1;
        sb_tgt_d   = sel_tgt;
      end
      S_MASK: begin
        mrf_wr_d = 1'b1;
        mrf_wa_d = sel_tgt[2:0];
        mrf_wd_d = mwd;
        sb_clr_d = 1'b1;
        sb_tgt_d = sel_tgt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      o_mem_q[wr_ptr_q] <= in_o;
      t_mem_q[wr_ptr_q] <= in_t;
      m_mem_q[wr_ptr_q] <= in_mask;
      z_mem_q[wr_ptr_q] <= in_zero;
      c_mem_q[wr_ptr_q] <= in_cmp;
      g_mem_q[wr_ptr_q] <= in_tgt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rf_wr_q    <= 1'b0;
      rf_wa_q    <= '0;
      rf_wbeat_q <= 1'b0;
      rf_wd_q    <= '0;
      mrf_wr_q   <= 1'b0;
      mrf_wa_q   <= '0;
      mrf_wd_q   <= '0;
      sb_clr_q   <= 1'b0;
      sb_tgt_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rf_wr_q    <= rf_wr_d;
      rf_wa_q    <= rf_wa_d;
      rf_wbeat_q <= rf_wbeat_d;
      rf_wd_q    <= rf_wd_d;
      mrf_wr_q   <= mrf_wr_d;
      mrf_wa_q   <= mrf_wa_d;
      mrf_wd_q   <= mrf_wd_d;
      sb_clr_q   <= sb_clr_d;
      sb_tgt_q   <= sb_tgt_d;
    end
  end

  assign rf_wr    = rf_wr_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wbeat = rf_wbeat_q;
  assign rf_wd    = rf_wd_q;
  assign mrf_wr   = mrf_wr_q;
  assign mrf_wa   = mrf_wa_q;
  assign mrf_wd   = mrf_wd_q;
  assign sb_clr   = sb_clr_q;
  assign sb_tgt   = sb_tgt_q;

endmodule

// File: tb/tb_rfphoenix_vec_wb.sv
// Bench for rfphoenix_vec_wb: directed timing scenarios plus random traffic
// checked against an in-order queue of expected register-file writes.
module tb_rfphoenix_vec_wb;

  localparam int unsigned NL = 16;
  localparam int unsigned LW = 32;
  localparam int unsigned RW = 6;
  localparam int unsigned VW = NL * LW;
  localparam int unsigned HW = VW / 2;

  logic          clk, rst_n;
  logic          in_valid, in_ready, in_zero, in_cmp, flush;
  logic [VW-1:0] in_o, in_t;
  logic [NL-1:0] in_mask;
  logic [RW-1:0] in_tgt;
  logic          rf_wr, rf_wbeat, mrf_wr, sb_clr, busy;
  logic [RW-1:0] rf_wa, sb_tgt;
  logic [HW-1:0] rf_wd;
  logic [2:0]    mrf_wa;
  logic [NL-1:0] mrf_wd;

  rfphoenix_vec_wb #(.NLANES(NL), .LW(LW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_o(in_o), .in_t(in_t), .in_mask(in_mask), .in_zero(in_zero),
    .in_cmp(in_cmp), .in_tgt(in_tgt), .flush(flush),
    .rf_wr(rf_wr), .rf_wa(rf_wa), .rf_wbeat(rf_wbeat), .rf_wd(rf_wd),
    .mrf_wr(mrf_wr), .mrf_wa(mrf_wa), .mrf_wd(mrf_wd),
    .sb_clr(sb_clr), .sb_tgt(sb_tgt), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          is_mask;
    logic [RW-1:0] tgt;
    logic          beat;
    logic [HW-1:0] wd;
    logic [NL-1:0] mwd;
    logic          last;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk = 0;
  int  n_pass = 0;

  task automatic chk(input string tag, input logic [HW-1:0] got, input logic [HW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected writes for one accepted entry, straight from the lane rules.
  task automatic model_push(input logic [VW-1:0] o, input logic [VW-1:0] t,
                            input logic [NL-1:0] m, input logic z, input logic c,
                            input logic [RW-1:0] tg);
    logic [VW-1:0] mg;
    logic [NL-1:0] mw;
    wr_t b;
    for (int n = 0; n < NL; n++) begin
      mg[n*LW +: LW] = m[n] ? o[n*LW +: LW] : (z ? '0 : t[n*LW +: LW]);
      mw[n] = o[n] & m[n];
    end
    b = '0;
    b.tgt = tg;
    if (c) begin
      b.is_mask = 1'b1;
      b.mwd = mw;
      b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      b.wd = mg[HW-1:0];
      exp_q.push_back(b);
      b.beat = 1'b1;
      b.wd = mg[VW-1:HW];
      b.last = 1'b1;
      exp_q.push_back(b);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int n = 0; n < NL; n++) v[n*LW +: LW] = $urandom;
    return v;
  endfunction

  task automatic drive(input logic [VW-1:0] o, input logic [VW-1:0] t,
                       input logic [NL-1:0] m, input logic z, input logic c,
                       input logic [RW-1:0] tg);
    in_o = o; in_t = t; in_mask = m; in_zero = z; in_cmp = c; in_tgt = tg;
  endtask

  task automatic push_one(input logic [VW-1:0] o, input logic [VW-1:0] t,
                          input logic [NL-1:0] m, input logic z, input logic c,
                          input logic [RW-1:0] tg);
    drive(o, t, m, z, c, tg);
    in_valid = 1'b1;
    if (in_ready && !flush) model_push(o, t, m, z, c, tg);
    step();
    in_valid = 1'b0;
  endtask

  // Every write the DUT shows must be the next expected one, in order.
  always @(negedge clk) begin
    wr_t it;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (rf_wr || mrf_wr) begin
        chk("wr_exclusive", HW'(rf_wr & mrf_wr), '0);
        if (exp_q.size() == 0) begin
          chk("unexpected_write", HW'(rf_wr | mrf_wr), '0);
        end else begin
          it = exp_q.pop_front();
          if (it.is_mask) begin
            chk("mrf_wr", HW'(mrf_wr), HW'(1'b1));
            chk("mrf_wa", HW'(mrf_wa), HW'(it.tgt[2:0]));
            chk("mrf_wd", HW'(mrf_wd), HW'(it.mwd));
          end else begin
            chk("rf_wr", HW'(rf_wr), HW'(1'b1));
            chk("rf_wa", HW'(rf_wa), HW'(it.tgt));
            chk("rf_wbeat", HW'(rf_wbeat), HW'(it.beat));
            chk("rf_wd", rf_wd, it.wd);
          end
          chk("sb_clr", HW'(sb_clr), HW'(it.last));
          if (it.last) chk("sb_tgt", HW'(sb_tgt), HW'(it.tgt));
        end
      end else begin
        chk("stray_sb_clr", HW'(sb_clr), '0);
      end
      if (flush) exp_q.delete();
    end
  end

  logic [VW-1:0] vo, vt;
  logic [VW-1:0] bp_o [3];
  logic [NL-1:0] bp_m [3];
  logic [8:0]    hist_wr, hist_sb;
  logic          r;
  int            nacc, acc3;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0;
    drive('0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rf_wr", HW'(rf_wr), '0);
    chk("rst_mrf_wr", HW'(mrf_wr), '0);
    chk("rst_sb_clr", HW'(sb_clr), '0);
    chk("rst_rf_wd", rf_wd, '0);
    chk("rst_in_ready", HW'(in_ready), HW'(1'b1));
    chk("rst_busy", HW'(busy), '0);
    rst_n = 1'b1;
    step();

    // Unmasked vector, lanes n+1, target 5
    for (int n = 0; n < NL; n++) vo[n*LW +: LW] = LW'(n + 1);
    push_one(vo, '0, 16'hFFFF, 1'b0, 1'b0, 6'd5);
    step();
    chk("t1_b0_wr", HW'(rf_wr), HW'(1'b1));
    chk("t1_b0_beat", HW'(rf_wbeat), '0);
    chk("t1_b0_wd", rf_wd, vo[HW-1:0]);
    chk("t1_b0_sb", HW'(sb_clr), '0);
    step();
    chk("t1_b1_beat", HW'(rf_wbeat), HW'(1'b1));
    chk("t1_b1_wd", rf_wd, vo[VW-1:HW]);
    chk("t1_b1_sb", HW'(sb_clr), HW'(1'b1));
    chk("t1_b1_tgt", HW'(sb_tgt), HW'(6'd5));
    step();

    // Predication: merge vs zero on the disabled upper lanes
    for (int n = 0; n < NL; n++) begin
      vo[n*LW +: LW] = 32'h1000_0000 + LW'(n);
      vt[n*LW +: LW] = 32'hDEAD_BEEF;
    end
    for (int z = 0; z < 2; z++) begin
      push_one(vo, vt, 16'h00FF, z[0], 1'b0, 6'd12);
      step();
      chk("t2_lo", rf_wd, vo[HW-1:0]);
      step();
      chk("t2_hi", rf_wd, (z == 0) ? {8{32'hDEAD_BEEF}} : '0);
      step();
    end

    // Compare result into the mask RF
    vo = '0;
    vo[31:0] = 32'h0000_A5A5;
    push_one(vo, '0, 16'hFF0F, 1'b0, 1'b1, 6'd3);
    chk("t3_pre", HW'(mrf_wr), '0);
    step();
    chk("t3_mrf_wr", HW'(mrf_wr), HW'(1'b1));
    chk("t3_mrf_wa", HW'(mrf_wa), HW'(3'd3));
    chk("t3_mrf_wd", HW'(mrf_wd), HW'(16'hA505));
    chk("t3_sb", HW'(sb_clr), HW'(1'b1));
    chk("t3_rf_wr", HW'(rf_wr), '0);
    step();
    chk("t3_single", HW'(mrf_wr), '0);
    step();

    // Back-pressure: three vectors with in_valid held
    for (int k = 0; k < 3; k++) begin
      bp_o[k] = rand_vec();
      bp_m[k] = NL'($urandom);
    end
    drive(bp_o[0], '0, bp_m[0], 1'b1, 1'b0, 6'd20);
    in_valid = 1'b1; nacc = 0; acc3 = 0; hist_wr = '0; hist_sb = '0;
    for (int i = 1; i <= 9; i++) begin
      r = in_valid && in_ready;
      if (r) model_push(in_o, in_t, in_mask, in_zero, in_cmp, in_tgt);
      step();
      if (r) begin
        nacc++;
        if (nacc == 3) begin
          acc3 = i;
          in_valid = 1'b0;
        end else begin
          drive(bp_o[nacc], '0, bp_m[nacc], 1'b1, 1'b0, RW'(20 + nacc));
        end
      end
      hist_wr[i-1] = rf_wr;
      hist_sb[i-1] = sb_clr;
      if (i == 2) chk("bp_ready_low", HW'(in_ready), '0);
    end
    chk("bp_third_edge", HW'(acc3), HW'(5));
    chk("bp_rf_wr_run", HW'(hist_wr), HW'(9'h07E));
    chk("bp_sb_cycles", HW'(hist_sb), HW'(9'h054));
    step();

    // Flush during BEAT0 with two entries queued
    push_one(rand_vec(), rand_vec(), 16'hFFFF, 1'b0, 1'b0, 6'd10);
    drive(rand_vec(), rand_vec(), 16'h0F0F, 1'b0, 1'b0, 6'd11);
    in_valid = 1'b1;
    if (in_ready) model_push(in_o, in_t, in_mask, in_zero, in_cmp, in_tgt);
    step();
    chk("fl_beat0", HW'(rf_wr), HW'(1'b1));
    drive(rand_vec(), '0, 16'hFFFF, 1'b0, 1'b0, 6'd13);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_rf_wr", HW'(rf_wr), '0);
    chk("fl_busy", HW'(busy), '0);
    chk("fl_ready", HW'(in_ready), HW'(1'b1));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("fl_no_sb", HW'(sb_clr), '0);
    end

    // Asynchronous reset during BEAT1
    push_one(rand_vec(), rand_vec(), 16'hAAAA, 1'b1, 1'b0, 6'd7);
    step();
    step();
    chk("rs_in_beat1", HW'(rf_wbeat), HW'(1'b1));
    #2 rst_n = 1'b0;
    #1;
    chk("rs_rf_wr", HW'(rf_wr), '0);
    chk("rs_sb_clr", HW'(sb_clr), '0);
    chk("rs_rf_wd", rf_wd, '0);
    chk("rs_ready", HW'(in_ready), HW'(1'b1));
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    push_one(rand_vec(), rand_vec(), 16'h5555, 1'b0, 1'b0, 6'd9);
    step();
    chk("rs_new_b0", HW'(rf_wa), HW'(6'd9));
    step();
    chk("rs_new_sb", HW'(sb_tgt), HW'(6'd9));
    step();

    // Random traffic against the expected-write queue
    for (int c = 0; c < 600; c++) begin
      flush = ($urandom_range(0, 39) == 0);
      in_valid = ($urandom_range(0, 9) < 7);
      drive(rand_vec(), rand_vec(), NL'($urandom), 1'($urandom), ($urandom_range(0, 9) < 3),
            RW'($urandom));
      if (in_valid && in_ready && !flush)
        model_push(in_o, in_t, in_mask, in_zero, in_cmp, in_tgt);
      step();
    end
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 30 && busy; i++) step();
    step();
    chk("drain_busy", HW'(busy), '0);
    chk("drain_queue", HW'(exp_q.size()), '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rfphoenix_vec_wb.md
# rfphoenix_vec_wb

Vector writeback stage sitting directly downstream of the vector ALU. It accepts one ALU result vector per handshake and applies per-lane predication: merge with the old target value or zero the disabled lanes. It then writes the vector into the half-width vector register file write port over two beats, or into the mask register file in one beat for compare results. A scoreboard clear is issued once the write completes, and a 2-entry FIFO decouples the ALU from the write port.

## Interface
Parameters:
- NLANES, 16, vector lanes (even, ≥4)
- LW, 32, lane width in bits
- RW, 6, vector register tag width
Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  ALU result valid
- in_ready  out  1  stage can accept; equals FIFO count < 2
- in_o  in  NLANES*LW  ALU result vector, lane n = bits [n*LW +: LW]
- in_t  in  NLANES*LW  old target register value (merge source)
- in_mask  in  NLANES  lane enable
- in_zero  in  1  1 = disabled lanes written 0; 0 = disabled lanes keep in_t
- in_cmp  in  1  compare op with scalar-packed result (ALU Tt=0)
- in_tgt  in  RW  target register (vector) or low 3 bits = mask register
- flush  in  1  discard all pending work
- rf_wr  out  1  vector RF write strobe
- rf_wa  out  RW  vector RF address
- rf_wbeat  out  1  0 = lanes 0..NLANES/2-1, 1 = upper half
- rf_wd  out  NLANES/2*LW  write data for the half
- mrf_wr  out  1  mask RF write strobe
- mrf_wa  out  3  mask register address
- mrf_wd  out  NLANES  mask data
- sb_clr  out  1  scoreboard clear pulse
- sb_tgt  out  RW  tag being cleared
- busy  out  1  FIFO non-empty or FSM not IDLE

## Operation
- FIFO: 2 entries, circular, 1-bit pointers, 2-bit count. Push on in_valid & in_ready. in_ready depends only on count; there is no same-cycle push-through at count==2.
- Merge, computed at FIFO head: lane n = in_mask[n] ? in_o[n] : (in_zero ? 0 : in_t[n]).
- Mask data: mrf_wd[n] = in_o lane 0 bit n & in_mask[n].
- FSM states IDLE, BEAT0, BEAT1, MASK:
  - IDLE: FIFO non-empty & head.cmp → MASK; non-empty & !cmp → BEAT0; empty → IDLE.
  - BEAT0 → BEAT1.
  - BEAT1 and MASK: pop head. Next state is chosen from the new head using the IDLE rules, with no idle bubble.
- Outputs are registered and reflect the current state:
  - BEAT0: rf_wr=1, rf_wbeat=0, rf_wd = merged lanes low half.
  - BEAT1: rf_wr=1, rf_wbeat=1, upper half, sb_clr=1, sb_tgt=tgt.
  - MASK: mrf_wr=1, mrf_wa=tgt[2:0], sb_clr=1.
- Flush: on the next edge count←0, pointers←0, FSM←IDLE, all strobes 0. A beat in progress is abandoned and no sb_clr is issued for dropped entries. A push in the flush cycle is ignored.
- Reset: FIFO empty, IDLE, and every output 0 except in_ready=1. Reset asserted mid-write drops the write.

## Timing
- Entry pushed at edge k into an empty stage in IDLE: BEAT0 is visible during cycle k+1→k+2, BEAT1 during k+2→k+3. Mask writes are visible during k+1→k+2.
- Throughput: one vector per 2 cycles, one compare result per cycle.
- Pop occurs at the end of BEAT1/MASK. in_ready rises in the cycle after the pop (count registered).
- sb_clr is exactly 1 cycle per completed entry, coincident with the final write strobe.
- rf_wr and mrf_wr are never high in the same cycle.

## Test plan
- Unmasked vector, NLANES=16, in_mask=16'hFFFF, tgt=5, lanes = n+1: BEAT0 rf_wd lanes 1..8, rf_wbeat=0; next cycle lanes 9..16, rf_wbeat=1, sb_clr=1, sb_tgt=5.
- Predication: in_mask=16'h00FF, in_t lanes=32'hDEAD_BEEF. With in_zero=0, upper beat is all DEADBEEF. With in_zero=1, upper beat is all 0.
- Compare: in_cmp=1, lane0=32'h0000_A5A5, in_mask=16'hFF0F, tgt=3: single cycle with mrf_wr=1, mrf_wa=3, mrf_wd=16'hA505, sb_clr=1, rf_wr=0.
- Back-pressure: push 3 vectors back-to-back with in_valid held. in_ready=0 after two pushes and the third is accepted after the first BEAT1 pop. rf_wr is continuous for 6 cycles, with sb_clr on cycles 2, 4 and 6.
- Flush during BEAT0 with 2 entries queued: the next cycle shows rf_wr=0 and busy=0, no sb_clr is ever issued for those tags, and in_ready=1.
- Reset asserted asynchronously during BEAT1: outputs go to 0 immediately and in_ready=1. After release, a new vector writes normally.
